cpu_rf_wr_arbiter: RTL
======================

Name: cpu_rf_wr_arbiter

Overview:
- Shares the register bank's single write port (wen3/a3/wd3) between three writeback sources: ALU, load/store unit (LSU) and debug.
- Arbitrates one write per cycle with a valid/ready handshake on each source.
- Registers the winning write before it reaches the register bank.
- Filters writes to x0, so the bank never sees wen3=1 with a3=0.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- DBG_BURST_MAX, 4, maximum consecutive debug grants while a CPU source waits (range 1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU write request
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_wd  input  DATA_WIDTH  ALU write data
- alu_ready  output  1  ALU request accepted this cycle
- lsu_valid  input  1  LSU write request
- lsu_rd  input  ADDR_WIDTH  LSU destination register
- lsu_wd  input  DATA_WIDTH  LSU write data
- lsu_ready  output  1  LSU request accepted this cycle
- dbg_valid  input  1  debug write request
- dbg_rd  input  ADDR_WIDTH  debug destination register
- dbg_wd  input  DATA_WIDTH  debug write data
- dbg_ready  output  1  debug request accepted this cycle
- wen3  output  1  register bank write enable (registered)
- a3  output  ADDR_WIDTH  register bank write address (registered)
- wd3  output  DATA_WIDTH  register bank write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - wen3=0, a3=0, wd3=0.
  - RR pointer favours ALU; dbg_cnt=0.
  - All *_ready forced 0 while rst_n is low.
  - Reset mid-operation discards any in-flight output write. No replay.
- Handshake:
  - Transfer occurs when valid && ready on a rising clk edge.
  - A source holds valid, rd and wd stable until ready.
  - ready is combinational from the valids plus arbiter state. No dependency on rd/wd.
  - At most one ready high per cycle.
- Arbitration, per cycle:
  - dbg wins if dbg_valid and (dbg_cnt < DBG_BURST_MAX or no CPU source valid).
  - Otherwise, if both alu_valid and lsu_valid, round-robin: the RR pointer selects the winner, then flips to the other source after the grant.
  - Otherwise the single valid CPU source wins.
  - A sole valid CPU source does not change the RR pointer.
- dbg_cnt (starvation guard):
  - Increments, saturating at DBG_BURST_MAX, on each dbg grant made while alu_valid or lsu_valid is high.
  - Clears on any CPU grant, or on any cycle where no CPU source is valid.
  - At DBG_BURST_MAX with a CPU source valid, the CPU source is granted, then dbg_cnt clears.
- Output stage:
  - On a grant: a3 <= winner rd, wd3 <= winner wd, wen3 <= (winner rd != 0).
  - With no grant: wen3 <= 0, and a3/wd3 hold their previous values.
  - Latency: handshake at edge N → wen3 high during cycle N+1 → bank written at edge N+2.
- x0 writes:
  - Accepted (ready=1) and dropped; wen3 stays 0.
  - Still count as a grant for RR and dbg_cnt.
- Back-to-back grants every cycle are allowed; throughput is one write per cycle.
- No address hazard checking: same-rd writes from different sources commit in grant order.

Optional Feature:
- Macro: CPU_RF_ARB_PERF_EN.
- Defined: adds outputs
  - conflict_cnt [15:0]: cycles with ≥2 valid sources.
  - x0_drop_cnt [15:0]: accepted writes with rd=0.
  - Both counters are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ALU only, rd=5, wd=32'hDEAD_BEEF, valid 1 cycle → alu_ready=1 same cycle; next cycle wen3=1, a3=5, wd3=32'hDEAD_BEEF; following cycle wen3=0.
- ALU and LSU both valid for 4 cycles (alu rd=1, lsu rd=2, new data each grant) after reset → grants ALU, LSU, ALU, LSU; a3 sequence 1,2,1,2 with one-cycle lag.
- dbg_valid and alu_valid held high, DBG_BURST_MAX=4 → dbg granted 4 cycles, ALU granted cycle 5, dbg granted cycle 6.
- LSU write rd=0, wd=32'h1234 → lsu_ready=1; wen3 stays 0; x0_drop_cnt=1 when CPU_RF_ARB_PERF_EN is defined.
- rst_n asserted the cycle after an ALU handshake (rd=7) → wen3 goes 0 asynchronously, and no write to x7 occurs. After release with valids low: wen3=0 and all ready=0.
- dbg_valid alone for 10 cycles, rd=3..12 → dbg granted every cycle with no burst limit applied (dbg_cnt stays 0); a3 tracks 3..12.

Source files
------------

// File: rtl/cpu_rf_wr_arbiter.sv
// Register-file write-port arbiter: ALU, LSU and debug writeback sources share the
// single bank write port (wen3/a3/wd3). Debug has priority, but a burst limit
// (DBG_BURST_MAX) stops it from starving a waiting CPU source. ALU and LSU are
// round-robin arbitrated when both are requesting. The winning write is registered
// before it reaches the bank. Writes to x0 are accepted and then dropped.
// Optional build macro CPU_RF_ARB_PERF_EN adds the conflict_cnt and x0_drop_cnt
// saturating performance counters.
module cpu_rf_wr_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DBG_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_wd,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wd,
  output logic                  lsu_ready,
  input  logic                  dbg_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_rd,
  input  logic [DATA_WIDTH-1:0] dbg_wd,
  output logic                  dbg_ready,
  output logic                  wen3,
  output logic [ADDR_WIDTH-1:0] a3,
`ifdef CPU_RF_ARB_PERF_EN
  output logic [15:0]           conflict_cnt,
  output logic [15:0]           x0_drop_cnt,
`endif
  output logic [DATA_WIDTH-1:0] wd3
);

  localparam logic [3:0] BurstMax = 4'(DBG_BURST_MAX);

  logic                  rr_q, rr_d;            // 0: ALU favoured, 1: LSU favoured
  logic [3:0]            dbg_cnt_q, dbg_cnt_d;
  logic                  wen3_q, wen3_d;
  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

  logic                  cpu_any;
  logic                  alu_gnt, lsu_gnt, dbg_gnt, any_gnt;
  logic [ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_wd;

  // Grant decision; grants are masked during reset so no ready leaks out.
  always_comb begin
    cpu_any = alu_valid | lsu_valid;
    dbg_gnt = rst_n & dbg_valid & ((dbg_cnt_q < BurstMax) | ~cpu_any);
    alu_gnt = rst_n & ~dbg_gnt & alu_valid & (~lsu_valid | ~rr_q);
    lsu_gnt = rst_n & ~dbg_gnt & lsu_valid & (~alu_valid | rr_q);
    any_gnt = alu_gnt | lsu_gnt | dbg_gnt;
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign dbg_ready = dbg_gnt;

  // Select the winner's address and data.
  always_comb begin
    gnt_rd = '0;
    gnt_wd = '0;
    if (dbg_gnt) begin
      gnt_rd = dbg_rd;
      gnt_wd = dbg_wd;
    end else if (alu_gnt) begin
      gnt_rd = alu_rd;
      gnt_wd = alu_wd;
    end else if (lsu_gnt) begin
      gnt_rd = lsu_rd;
      gnt_wd = lsu_wd;
    end
  end

  // Next-state for the round-robin pointer, debug burst counter and output stage.
  always_comb begin
    rr_d      = rr_q;
    dbg_cnt_d = dbg_cnt_q;
    wen3_d    = 1'b0;
    a3_d      = a3_q;
    wd3_d     = wd3_q;

    // Pointer only moves on a contested ALU/LSU grant.
    if (alu_valid && lsu_valid && (alu_gnt || lsu_gnt)) begin
      rr_d = alu_gnt;
    end

    if (!cpu_any || alu_gnt || lsu_gnt) begin
      dbg_cnt_d = '0;
    end else if (dbg_gnt && (dbg_cnt_q < BurstMax)) begin
      dbg_cnt_d = dbg_cnt_q + 4'd1;
    end

    if (any_gnt) begin
      a3_d   = gnt_rd;
      wd3_d  = gnt_wd;
      wen3_d = (gnt_rd != '0);
    end
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      dbg_cnt_q <= '0;
      wen3_q    <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      dbg_cnt_q <= dbg_cnt_d;
      wen3_q    <= wen3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
    end
  end

  assign wen3 = wen3_q;
  assign a3   = a3_q;
  assign wd3  = wd3_q;

`ifdef CPU_RF_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] x0_drop_q, x0_drop_d;
  logic [1:0]  n_valid;

  // Saturating performance counters.
  always_comb begin
    n_valid    = {1'b0, alu_valid} + {1'b0, lsu_valid} + {1'b0, dbg_valid};
    conflict_d = conflict_q;
    x0_drop_d  = x0_drop_q;
    if ((n_valid >= 2'd2) && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
    if (any_gnt && (gnt_rd == '0) && (x0_drop_q != 16'hFFFF)) begin
      x0_drop_d = x0_drop_q + 16'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      x0_drop_q  <= '0;
    end else begin
      conflict_q <= conflict_d;
      x0_drop_q  <= x0_drop_d;
    end
  end

  assign conflict_cnt = conflict_q;
  assign x0_drop_cnt  = x0_drop_q;
`endif

endmodule
